mem2_sub1: RTL
==============

Name: mem2_sub1

Overview:
- Second memory stage (M2) of the sub (slot-1) issue pipe in the dual-issue core.
- Consumes the M1-sub bus and feeds write-back (WS).
- Holds pipeline state in a 2-entry buffer: a main slot plus a skid slot. This makes m2s_allowin a pure register output, so WS backpressure never forms a combinational path into M1.
- Exports forwarding info for both held entries.

Parameters:
- IN_WD, 75, width of m1s_to_m2s_bus.
  - Layout: first[74], rf_wen[73:70], gr_we[69], dest[68:64], alu_result[63:32], pc[31:0].
- OUT_WD, 74, width of m2s_to_ws_bus.
  - Layout: first[73], rf_wen[72:69], dest[68:64], wdata[63:32], pc[31:0].

Ports:
- clk  input  1  stage clock; one clock domain, all state updates on its rising edge.
- resetn  input  1  asynchronous, active-low reset.
- m1s_valid  input  1  M1-sub holds a valid instruction.
- m1s_to_m2s_bus  input  IN_WD  instruction payload from M1-sub.
- m2s_allowin  output  1  M2-sub can accept; registered.
- ws_allowin  input  1  WS can accept this cycle.
- flush  input  1  exception/eret flush; synchronous.
- m2s_to_ws_valid  output  1  main slot is valid.
- m2s_to_ws_bus  output  OUT_WD  main-slot payload.
- m2s_rd  output  5  main-slot dest.
- m2s_reg_write  output  1  main-slot valid & gr_we.
- m2s_result  output  32  main-slot alu_result.
- m2s_sk_rd  output  5  skid-slot dest.
- m2s_sk_reg_write  output  1  skid-slot valid & gr_we.
- m2s_sk_result  output  32  skid-slot alu_result.
- m2s_stall_cnt  output  32  stall counter (see Optional Feature).

Behaviour:
- State:
  - main_valid and main payload.
  - skid_valid and skid payload.
- Handshakes:
  - in_fire = m1s_valid & m2s_allowin.
  - out_fire = main_valid & ws_allowin.
- m2s_allowin is driven as ~skid_valid, taken directly from the flop.
- Update rules, applied at the clock edge with flush=0:
  - skid_valid=1 and out_fire: main takes skid; skid_valid goes to 0. in_fire cannot occur because allowin=0.
  - skid_valid=0, in_fire, and (main_valid=0 or out_fire): main takes the input; main_valid goes to 1.
  - skid_valid=0, in_fire, main_valid=1, and no out_fire: skid takes the input; skid_valid goes to 1; main is held.
  - skid_valid=0, no in_fire, and out_fire: main_valid goes to 0.
  - Otherwise: hold.
- Ordering: the skid entry is always younger than main. Entries leave in FIFO order; none are dropped or duplicated.
- Latency:
  - 1 cycle from in_fire to m2s_to_ws_valid when the stage is empty.
  - Throughput is 1/cycle while ws_allowin=1.
- Output bus:
  - rf_wen is forced to 4'b0 when main_valid=0.
  - wdata = alu_result.
  - The first bit passes through unchanged.
- Flush:
  - Has priority over every other event in the same cycle.
  - Next edge: main_valid=0, skid_valid=0, m2s_allowin=1.
  - Any same-cycle in_fire is discarded. Payload registers may keep stale data.
- Forwarding:
  - When both slots write the same dest, the consumer gives priority to the skid set (the younger entry).
  - Both *_reg_write outputs are 0 when their slot is invalid.
- Reset (resetn=0, asynchronous):
  - main_valid=0, skid_valid=0, m2s_allowin=1.
  - All payload registers are 0, so every bus/forwarding output is 0.
  - m2s_stall_cnt=0.
  - Reset asserted mid-transfer discards both entries.
- The stage is an exact pass-through of payload fields; there is no arithmetic.

Optional Feature:
- Macro: M2S_STALL_CNT_EN.
- Defined:
  - m2s_stall_cnt increments by 1 every cycle with main_valid=1 & ws_allowin=0.
  - It wraps from 32'hFFFFFFFF to 0 and is cleared only by reset; flush does not clear it.
- Undefined: the counter is absent and m2s_stall_cnt is tied to 32'h0.

Test Plan:
- Reset release, then inject pc=0xBFC00000, dest=5, gr_we=1, alu_result=0x1234, with ws_allowin=1 -> next cycle m2s_to_ws_valid=1, wdata=0x1234, dest=5, m2s_reg_write=1; following cycle valid=0.
- Stream 4 back-to-back instructions with ws_allowin=1 -> 4 consecutive output cycles in order; m2s_allowin stays 1 throughout.
- Hold ws_allowin=0 while feeding A then B -> A in main, B in skid; m2s_allowin=0; m2s_sk_rd=B.dest. Then raise ws_allowin for 2 cycles -> A then B delivered; allowin returns to 1.
- State as above (A in main, B in skid), assert flush together with m1s_valid=1 carrying C -> next cycle both valids are 0, C is not captured, allowin=1.
- Inject an instruction with gr_we=0, rf_wen=4'hF -> m2s_reg_write=0, and the output bus carries rf_wen=4'hF while valid. Once invalid, rf_wen reads 4'h0.
- With M2S_STALL_CNT_EN defined: 10 cycles of main_valid=1, ws_allowin=0 -> m2s_stall_cnt=10. Assert flush -> count is retained; assert resetn=0 -> 0.

Source files
------------

// File: rtl/mem2_sub1.sv
// mem2_sub1 : second memory stage (M2) of the slot-1 (sub) issue pipe.
//
// Holds up to two instructions: a main slot that drives write-back and a
// skid slot that absorbs one extra instruction when WS stalls. Because the
// skid slot exists, m2s_allowin is simply the inverse of the skid valid flop.
// That keeps WS backpressure from forming a combinational path into M1.
//
// Ports:
//   clk, resetn          clock; asynchronous active-low reset
//   m1s_valid            M1-sub holds a valid instruction
//   m1s_to_m2s_bus       payload {first, rf_wen, gr_we, dest, alu_result, pc}
//   m2s_allowin          registered ready back to M1-sub
//   ws_allowin           WS can accept this cycle
//   flush                synchronous exception/eret flush
//   m2s_to_ws_valid/bus  main-slot valid and payload {first, rf_wen, dest, wdata, pc}
//   m2s_rd/reg_write/result           forwarding info, main slot
//   m2s_sk_rd/sk_reg_write/sk_result  forwarding info, skid slot (younger)
//   m2s_stall_cnt        stall cycle counter
//
// Optional feature: define M2S_STALL_CNT_EN to build the stall counter.
// Without it, m2s_stall_cnt is tied to zero.
module mem2_sub1 #(
  parameter int IN_WD  = 75,
  parameter int OUT_WD = 74
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              m1s_valid,
  input  logic [IN_WD-1:0]  m1s_to_m2s_bus,
  output logic              m2s_allowin,
  input  logic              ws_allowin,
  input  logic              flush,
  output logic              m2s_to_ws_valid,
  output logic [OUT_WD-1:0] m2s_to_ws_bus,
  output logic [4:0]        m2s_rd,
  output logic              m2s_reg_write,
  output logic [31:0]       m2s_result,
  output logic [4:0]        m2s_sk_rd,
  output logic              m2s_sk_reg_write,
  output logic [31:0]       m2s_sk_result,
  output logic [31:0]       m2s_stall_cnt
);

  logic             main_vld_p1;
  logic             skid_vld_p1;
  logic [IN_WD-1:0] main_bus_p1;
  logic [IN_WD-1:0] skid_bus_p1;

  logic in_fire;
  logic out_fire;

  assign m2s_allowin = ~skid_vld_p1;
  assign in_fire     = m1s_valid & m2s_allowin;
  assign out_fire    = main_vld_p1 & ws_allowin;

  // ---- M1 -> M2 boundary: valid flags ----
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      main_vld_p1 <= 1'b0;
      skid_vld_p1 <= 1'b0;
    end else if (flush) begin
      main_vld_p1 <= 1'b0;
      skid_vld_p1 <= 1'b0;
    end else if (skid_vld_p1) begin
      // skid moves into main; main stays valid
      if (out_fire) skid_vld_p1 <= 1'b0;
    end else if (in_fire) begin
      if (!main_vld_p1 || out_fire) main_vld_p1 <= 1'b1;
      else                          skid_vld_p1 <= 1'b1;
    end else if (out_fire) begin
      main_vld_p1 <= 1'b0;
    end
  end

  // ---- M1 -> M2 boundary: payload ----
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      main_bus_p1 <= '0;
      skid_bus_p1 <= '0;
    end else if (!flush) begin
      if (skid_vld_p1) begin
        if (out_fire) main_bus_p1 <= skid_bus_p1;
      end else if (in_fire) begin
        if (!main_vld_p1 || out_fire) main_bus_p1 <= m1s_to_m2s_bus;
        else                          skid_bus_p1 <= m1s_to_m2s_bus;
      end
    end
  end

  // ---- M2 -> WS boundary ----
  assign m2s_to_ws_valid = main_vld_p1;
  assign m2s_to_ws_bus   = {main_bus_p1[74],
                            main_bus_p1[73:70] & {4{main_vld_p1}},
                            main_bus_p1[68:64],
                            main_bus_p1[63:32],
                            main_bus_p1[31:0]};

  assign m2s_rd           = main_bus_p1[68:64];
  assign m2s_reg_write    = main_vld_p1 & main_bus_p1[69];
  assign m2s_result       = main_bus_p1[63:32];
  assign m2s_sk_rd        = skid_bus_p1[68:64];
  assign m2s_sk_reg_write = skid_vld_p1 & skid_bus_p1[69];
  assign m2s_sk_result    = skid_bus_p1[63:32];

`ifdef M2S_STALL_CNT_EN
  logic [31:0] stall_cnt_p1;

  // Counts cycles where a valid main entry is blocked by WS; flush does not clear it.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                         stall_cnt_p1 <= 32'h0;
    else if (main_vld_p1 && !ws_allowin) stall_cnt_p1 <= stall_cnt_p1 + 32'h1;
  end

  assign m2s_stall_cnt = stall_cnt_p1;
`else
  assign m2s_stall_cnt = 32'h0;
`endif

endmodule
